instr_fetch: RTL and testbench

Instruction fetch unit for the RI5CY-style core. It issues word requests to instruction memory over a request/grant/valid interface and buffers the returned words with their PCs in a small FIFO. It supplies the decode stage with one 32-bit instruction per cycle and raises the no-op flag whenever no valid instruction is available. It also handles redirects from jumps and taken branches, discarding in-flight wrong-path responses.

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction prefetch unit with request/grant/valid memory port
// Buffers fetched words with their PCs and presents one instruction per cycle to decode.
module instr_fetch #(
   parameter int                    WORD_WIDTH      = 32,
   parameter int                    FIFO_DEPTH      = 4,
   parameter int                    MAX_OUTSTANDING = 2,
   parameter logic [WORD_WIDTH-1:0] BOOT_ADDR       = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_enable_i,
   output logic                  instr_req_o,
   output logic [WORD_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [WORD_WIDTH-1:0] instr_rdata_i,
   input  logic                  jump_i,
   input  logic [WORD_WIDTH-1:0] jump_target_i,
   input  logic                  stall_i,
   output logic [WORD_WIDTH-1:0] instr_o,
   output logic [WORD_WIDTH-1:0] pc_o,
   output logic                  no_op_flag_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [WORD_WIDTH-1:0] INSTR_NOP = WORD_WIDTH'(32'h0000_0013);

   logic [WORD_WIDTH-1:0] fetch_pc;
   logic [WORD_WIDTH-1:0] rsp_pc;
   logic [WORD_WIDTH-1:0] last_pc;
   logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [WORD_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [CW-1:0]         fifo_cnt;
   logic [OW-1:0]         out_cnt;
   logic [OW-1:0]         discard_cnt;

   logic                  head_valid;
   logic                  room;
   logic                  out_room;
   logic                  grant;
   logic                  drop;
   logic                  push;
   logic                  pop;
   logic [WORD_WIDTH-1:0] target;

   assign target     = jump_target_i & ~WORD_WIDTH'(3);
   assign head_valid = (fifo_cnt != '0) && !jump_i;
   // Reserving a FIFO slot per outstanding request means a response never finds the buffer full.
   assign room       = (32'(fifo_cnt) + 32'(out_cnt)) < 32'(FIFO_DEPTH);
   assign out_room   = 32'(out_cnt) < 32'(MAX_OUTSTANDING);
   assign instr_req_o = rst_n && fetch_enable_i && !jump_i && out_room && room;
   assign grant      = instr_req_o && instr_gnt_i;
   assign drop       = discard_cnt != '0;
   assign push       = instr_rvalid_i && !drop && !jump_i;
   assign pop        = head_valid && !stall_i;

   assign instr_addr_o = fetch_pc;
   assign instr_o      = head_valid ? fifo_data[rd_ptr] : INSTR_NOP;
   assign pc_o         = head_valid ? fifo_pc[rd_ptr] : last_pc;
   assign no_op_flag_o = !head_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= BOOT_ADDR;
         rsp_pc      <= BOOT_ADDR;
         last_pc     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_cnt    <= '0;
         out_cnt     <= '0;
         discard_cnt <= '0;
      end else begin
         out_cnt <= out_cnt + OW'(grant) - OW'(instr_rvalid_i);
         if (head_valid) begin
            last_pc <= fifo_pc[rd_ptr];
         end
         if (jump_i) begin
            // Everything still in flight belongs to the old path; a response arriving now is dropped too.
            fetch_pc    <= target;
            rsp_pc      <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            discard_cnt <= out_cnt - OW'(instr_rvalid_i);
         end else begin
            if (grant) begin
               fetch_pc <= fetch_pc + WORD_WIDTH'(4);
            end
            if (instr_rvalid_i && drop) begin
               discard_cnt <= discard_cnt - OW'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
               rsp_pc <= rsp_pc + WORD_WIDTH'(4);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= instr_rdata_i;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_enable;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        jump;
   logic [31:0] jump_target;
   logic        stall;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        nop;

   instr_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_enable_i (fetch_enable),
      .instr_req_o    (req),
      .instr_addr_o   (addr),
      .instr_gnt_i    (gnt),
      .instr_rvalid_i (rvalid),
      .instr_rdata_i  (rdata),
      .jump_i         (jump),
      .jump_target_i  (jump_target),
      .stall_i        (stall),
      .instr_o        (instr),
      .pc_o           (pc),
      .no_op_flag_o   (nop)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc_n;
   int          lat;
   int          n_gnt;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic        s_req;
   logic [31:0] s_addr;
   logic [31:0] s_instr;
   logic [31:0] s_pc;
   logic        s_nop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bus cycle: memory drives its response, outputs are captured, grants are queued.
   task automatic cyc();
      if (mq_due.size() > 0 && mq_due[0] == cyc_n) begin
         rvalid = 1'b1;
         rdata  = mq_addr.pop_front();
         void'(mq_due.pop_front());
      end else begin
         rvalid = 1'b0;
         rdata  = 32'h0;
      end
      #1;
      s_req = req; s_addr = addr; s_instr = instr; s_pc = pc; s_nop = nop;
      if (req && gnt) begin
         mq_addr.push_back(addr);
         mq_due.push_back(cyc_n + lat);
         n_gnt++;
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      mq_addr.delete();
      mq_due.delete();
      rvalid = 1'b0;
      jump   = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc_n = 0;
      n_gnt = 0;
   endtask

   initial begin
      gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0; jump = 1'b0; jump_target = 32'h0;
      stall = 1'b0; fetch_enable = 1'b1; lat = 1; cyc_n = 0; n_gnt = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req", {31'b0, req}, 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_instr", instr, 32'h13);
      chk("rst_pc", pc, 32'h0);
      chk("rst_nop", {31'b0, nop}, 32'h1);

      // Streaming fetch with 1-cycle memory
      do_reset();
      cyc(); chk("s_c0_req", {31'b0, s_req}, 32'h1); chk("s_c0_addr", s_addr, 32'h0);
             chk("s_c0_nop", {31'b0, s_nop}, 32'h1);
      cyc(); chk("s_c1_addr", s_addr, 32'h4); chk("s_c1_nop", {31'b0, s_nop}, 32'h1);
      cyc(); chk("s_c2_instr", s_instr, 32'h0); chk("s_c2_pc", s_pc, 32'h0);
             chk("s_c2_nop", {31'b0, s_nop}, 32'h0); chk("s_c2_addr", s_addr, 32'h8);
      cyc(); chk("s_c3_instr", s_instr, 32'h4); chk("s_c3_pc", s_pc, 32'h4);
      cyc(); chk("s_c4_instr", s_instr, 32'h8); chk("s_c4_pc", s_pc, 32'h8);

      // Stall until the buffer fills, then drain
      stall = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (i >= 2) chk("st_hold_instr", s_instr, 32'h0);
      end
      chk("st_grants", n_gnt, 4);
      chk("st_req_off", {31'b0, s_req}, 32'h0);
      stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("st_drain_instr", s_instr, 32'(i * 4));
         chk("st_drain_nop", {31'b0, s_nop}, 32'h0);
         if (i == 1) begin
            chk("st_resume_req", {31'b0, s_req}, 32'h1);
            chk("st_resume_addr", s_addr, 32'h10);
         end
      end

      // Jump with two responses in flight on 3-cycle memory
      lat = 3;
      do_reset();
      cyc(); cyc();
      jump = 1'b1; jump_target = 32'h100;
      cyc(); chk("j3_c2_nop", {31'b0, s_nop}, 32'h1); chk("j3_c2_req", {31'b0, s_req}, 32'h0);
      jump = 1'b0;
      for (int i = 3; i <= 7; i++) begin
         cyc();
         chk("j3_wait_nop", {31'b0, s_nop}, 32'h1);
         if (i == 4) begin
            chk("j3_c4_req", {31'b0, s_req}, 32'h1);
            chk("j3_c4_addr", s_addr, 32'h100);
         end
      end
      cyc(); chk("j3_instr", s_instr, 32'h100); chk("j3_pc", s_pc, 32'h100);
             chk("j3_nop", {31'b0, s_nop}, 32'h0);

      // Jump coinciding with rvalid and stall, then a misaligned target
      lat = 1;
      stall = 1'b1;
      do_reset();
      cyc(); cyc();
      jump = 1'b1; jump_target = 32'h100;
      cyc(); chk("jr_c2_rvalid", {31'b0, rvalid}, 32'h1);
             chk("jr_c2_nop", {31'b0, s_nop}, 32'h1); chk("jr_c2_instr", s_instr, 32'h13);
      jump = 1'b0; stall = 1'b0;
      cyc(); chk("jr_c3_nop", {31'b0, s_nop}, 32'h1); chk("jr_c3_req", {31'b0, s_req}, 32'h1);
             chk("jr_c3_addr", s_addr, 32'h100);
      cyc(); chk("jr_c4_nop", {31'b0, s_nop}, 32'h1);
      cyc(); chk("jr_c5_instr", s_instr, 32'h100); chk("jr_c5_nop", {31'b0, s_nop}, 32'h0);
      jump = 1'b1; jump_target = 32'h203;
      cyc(); chk("ja_c6_nop", {31'b0, s_nop}, 32'h1);
      jump = 1'b0;
      cyc(); chk("ja_c7_addr", s_addr, 32'h200); chk("ja_c7_req", {31'b0, s_req}, 32'h1);
      cyc();
      cyc(); chk("ja_c9_instr", s_instr, 32'h200); chk("ja_c9_pc", s_pc, 32'h200);

      // Fetch enable dropped with one request outstanding
      fetch_enable = 1'b1;
      do_reset();
      cyc();
      fetch_enable = 1'b0;
      cyc(); chk("fe_c1_req", {31'b0, s_req}, 32'h0);
      cyc(); chk("fe_c2_instr", s_instr, 32'h0); chk("fe_c2_nop", {31'b0, s_nop}, 32'h0);
             chk("fe_c2_req", {31'b0, s_req}, 32'h0);
      cyc(); chk("fe_c3_nop", {31'b0, s_nop}, 32'h1); chk("fe_c3_req", {31'b0, s_req}, 32'h0);
      fetch_enable = 1'b1;
      cyc(); cyc();
      cyc(); chk("fe_c6_instr", s_instr, 32'h4); chk("fe_c6_nop", {31'b0, s_nop}, 32'h0);

      // Asynchronous reset pulse mid-stream
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req", {31'b0, req}, 32'h0);
      chk("ar_addr", addr, 32'h0);
      chk("ar_instr", instr, 32'h13);
      chk("ar_pc", pc, 32'h0);
      chk("ar_nop", {31'b0, nop}, 32'h1);
      mq_addr.delete();
      mq_due.delete();
      rvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
